// File: rtl/char_phy_pkg.sv
// Shared widths, FSM state encoding and wall-limit helpers for the character physics,
// pixel and block generators.
package char_phy_pkg;
    localparam int PHY_WIDTH        = 14;
    localparam int SIGNED_PHY_WIDTH = PHY_WIDTH + 1;

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_CHARGE = 2'd1;
    localparam logic [1:0] ST_AIR    = 2'd2;

    function automatic int calc_min_x(input int map_x_offset, input int wall_width);
        return map_x_offset + wall_width;
    endfunction

    function automatic int calc_max_x(input int map_x_offset, input int map_width_x,
                                      input int wall_width, input int char_width_x);
        return map_x_offset + map_width_x - wall_width - char_width_x;
    endfunction
endpackage

// File: rtl/phy_tick_gen.sv
// Free-running divider: phy_tick is high for the one cycle in which the counter
// sits at TICK_DIV-1.
module phy_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic phy_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign phy_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = phy_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/char_motion_ctrl.sv
// Character walk / charge / airborne physics, updated once per physics tick.
// Optional jump statistics outputs are built when CHAR_JUMP_STATS_EN is defined.
module char_motion_ctrl
    import char_phy_pkg::*;
#(
    parameter int TICK_DIV     = 1000000,
    parameter int MAP_X_OFFSET = 120,
    parameter int MAP_WIDTH_X  = 480,
    parameter int WALL_WIDTH   = 10,
    parameter int CHAR_WIDTH_X = 42,
    parameter int INIT_X       = 339,
    parameter int WALK_SPEED   = 2,
    parameter int H_JUMP_SPEED = 3,
    parameter int JUMP_GAIN    = 2,
    parameter int MAX_CHARGE   = 31,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 24
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        left_btn,
    input  logic                        right_btn,
    input  logic                        jump_btn,
    output logic [PHY_WIDTH-1:0]        char_abs_x,
    output logic [PHY_WIDTH-1:0]        char_abs_y,
    output logic [SIGNED_PHY_WIDTH-1:0] char_vy,
    output logic [1:0]                  char_state,
    output logic                        facing,
    output logic                        phy_tick
`ifdef CHAR_JUMP_STATS_EN
    ,
    output logic [15:0]                 jump_cnt,
    output logic [PHY_WIDTH-1:0]        max_height
`endif
);
    localparam int PW  = PHY_WIDTH;
    localparam int SW  = SIGNED_PHY_WIDTH;
    localparam int SWX = SW + 1;
    localparam int CW  = $clog2(MAX_CHARGE + 1);

    localparam logic [PW-1:0] MIN_X   = PW'(calc_min_x(MAP_X_OFFSET, WALL_WIDTH));
    localparam logic [PW-1:0] MAX_X   = PW'(calc_max_x(MAP_X_OFFSET, MAP_WIDTH_X, WALL_WIDTH, CHAR_WIDTH_X));
    localparam logic [PW-1:0] WALK    = PW'(WALK_SPEED);
    localparam logic [PW-1:0] X_RESET = PW'(INIT_X);
    localparam logic [CW-1:0] CHG_MAX = CW'(MAX_CHARGE);
    localparam logic signed [SW-1:0] VX_JUMP = SW'(H_JUMP_SPEED);
    localparam logic signed [SW:0] GRAV_W  = SWX'(GRAVITY);
    localparam logic signed [SW:0] FALL_W  = SWX'(-MAX_FALL);
    localparam logic signed [SW:0] MIN_X_W = SWX'(calc_min_x(MAP_X_OFFSET, WALL_WIDTH));
    localparam logic signed [SW:0] MAX_X_W = SWX'(calc_max_x(MAP_X_OFFSET, MAP_WIDTH_X, WALL_WIDTH, CHAR_WIDTH_X));
    localparam logic signed [SW:0] Y_TOP_W = SWX'((1 << PW) - 1);

    logic [2:0] btn_raw, btn_sync;
    logic       btn_l, btn_r, btn_j;

    assign btn_raw = {jump_btn, right_btn, left_btn};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic s1_q, s2_q;
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= btn_raw[gi];
                s2_q <= s1_q;
            end
        end
        assign btn_sync[gi] = s2_q;
    end

    assign btn_l = btn_sync[0];
    assign btn_r = btn_sync[1];
    assign btn_j = btn_sync[2];

    phy_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .phy_tick (phy_tick)
    );

    logic [PW-1:0]        x_q, x_d, y_q, y_d;
    logic signed [SW-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [1:0]           st_q, st_d;
    logic                 face_q, face_d;
    logic [CW-1:0]        chg_q, chg_d;
    logic signed [SW:0]   x_sum, y_sum, vy_dec;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        st_d   = st_q;
        face_d = face_q;
        chg_d  = chg_q;
        // One bit of headroom so walls, floor and ceiling can all be tested signed.
        x_sum  = $signed({2'b00, x_q}) + $signed({vx_q[SW-1], vx_q});
        y_sum  = $signed({2'b00, y_q}) + $signed({vy_q[SW-1], vy_q});
        vy_dec = $signed({vy_q[SW-1], vy_q}) - GRAV_W;
        if (phy_tick) begin
            case (st_q)
                ST_GROUND: begin
                    if (btn_j) begin
                        st_d  = ST_CHARGE;
                        chg_d = '0;
                    end else if (btn_r && !btn_l) begin
                        face_d = 1'b1;
                        x_d    = (x_q + WALK > MAX_X) ? MAX_X : x_q + WALK;
                    end else if (btn_l && !btn_r) begin
                        face_d = 1'b0;
                        x_d    = (x_q < MIN_X + WALK) ? MIN_X : x_q - WALK;
                    end
                end
                ST_CHARGE: begin
                    if (btn_j) begin
                        chg_d = (chg_q == CHG_MAX) ? chg_q : chg_q + 1'b1;
                    end else begin
                        st_d = ST_AIR;
                        vy_d = SW'(int'(chg_q) * JUMP_GAIN);
                        if (btn_r && !btn_l) begin
                            vx_d   = VX_JUMP;
                            face_d = 1'b1;
                        end else if (btn_l && !btn_r) begin
                            vx_d   = -VX_JUMP;
                            face_d = 1'b0;
                        end else begin
                            vx_d = '0;
                        end
                    end
                end
                ST_AIR: begin
                    if (x_sum < MIN_X_W) begin
                        x_d  = MIN_X;
                        vx_d = -vx_q;
                    end else if (x_sum > MAX_X_W) begin
                        x_d  = MAX_X;
                        vx_d = -vx_q;
                    end else begin
                        x_d = x_sum[PW-1:0];
                    end
                    vy_d = (vy_dec < FALL_W) ? FALL_W[SW-1:0] : vy_dec[SW-1:0];
                    if (y_sum <= 0) begin
                        y_d  = '0;
                        vx_d = '0;
                        vy_d = '0;
                        st_d = ST_GROUND;
                    end else if (y_sum > Y_TOP_W) begin
                        y_d  = '1;
                        vy_d = '0;
                    end else begin
                        y_d = y_sum[PW-1:0];
                    end
                end
                default: st_d = ST_GROUND;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q    <= X_RESET;
            y_q    <= '0;
            vx_q   <= '0;
            vy_q   <= '0;
            st_q   <= ST_GROUND;
            face_q <= 1'b1;
            chg_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            st_q   <= st_d;
            face_q <= face_d;
            chg_q  <= chg_d;
        end
    end

    assign char_abs_x = x_q;
    assign char_abs_y = y_q;
    assign char_vy    = vy_q;
    assign char_state = st_q;
    assign facing     = face_q;

`ifdef CHAR_JUMP_STATS_EN
    logic [15:0]   jump_cnt_q, jump_cnt_d;
    logic [PW-1:0] max_h_q, max_h_d;

    always_comb begin
        jump_cnt_d = (st_q == ST_CHARGE && st_d == ST_AIR) ? jump_cnt_q + 16'd1 : jump_cnt_q;
        max_h_d    = (y_q > max_h_q) ? y_q : max_h_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            jump_cnt_q <= '0;
            max_h_q    <= '0;
        end else begin
            jump_cnt_q <= jump_cnt_d;
            max_h_q    <= max_h_d;
        end
    end

    assign jump_cnt   = jump_cnt_q;
    assign max_height = max_h_q;
`endif
endmodule
